// File: rtl/serial_word_comparator_pkg.sv
// Shared definitions: FSM state encodings and the result code set, also consumed by the display driver.
// Pure declarations, no logic, no latency.
package serial_word_comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPARE = 2'b01,
        ST_DONE    = 2'b10
    } state_t;

    // One-hot result code: {gt, lt, eq}
    typedef logic [2:0] res_t;
    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_GT   = 3'b100;
    localparam res_t RES_LT   = 3'b010;
    localparam res_t RES_EQ   = 3'b001;

    function automatic res_t slice_res(input logic gt, input logic lt);
        if (gt)      return RES_GT;
        else if (lt) return RES_LT;
        else         return RES_EQ;
    endfunction

endpackage

// File: rtl/two_bit_comparator.sv
// Combinational magnitude compare of one 2-bit slice.
// Zero latency, no flow control.
module two_bit_comparator (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt,
    output logic       lt,
    output logic       eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/serial_word_comparator.sv
// Compares WIDTH-bit words two bits per clock, MSB first, stopping at the first unequal slice.
// Result and one-cycle done pulse one edge after the deciding slice; start only accepted in IDLE.
module serial_word_comparator
    import serial_word_comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b
);

    localparam int NSLICE = WIDTH / 2;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state_q, state_d;
    res_t             res_q, res_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sl_gt, sl_lt, sl_eq;

    two_bit_comparator u_slice (
        .a  (sa_q[WIDTH-1 -: 2]),
        .b  (sb_q[WIDTH-1 -: 2]),
        .gt (sl_gt),
        .lt (sl_lt),
        .eq (sl_eq)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    cnt_d   = '0;
                    res_d   = RES_NONE;
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                // Abort outranks any decision made on the same edge
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!sl_eq || (cnt_q == LAST)) begin
                    res_d   = slice_res(sl_gt, sl_lt);
                    state_d = ST_DONE;
                end else begin
                    sa_d  = sa_q << 2;
                    sb_d  = sb_q << 2;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            res_q   <= RES_NONE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy   = (state_q == ST_COMPARE);
    assign done   = (state_q == ST_DONE);
    assign a_gt_b = res_q[2];
    assign a_lt_b = res_q[1];
    assign a_eq_b = res_q[0];

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed bench for serial_word_comparator at WIDTH=8; outputs checked as {busy,done,gt,lt,eq}.
module tb_serial_word_comparator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic [7:0] a, b;
    logic       busy, done, a_gt_b, a_lt_b, a_eq_b;
    logic [4:0] outs;
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    serial_word_comparator #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .a_gt_b (a_gt_b),
        .a_lt_b (a_lt_b),
        .a_eq_b (a_eq_b)
    );

    assign outs = {busy, done, a_gt_b, a_lt_b, a_eq_b};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] exp);
        total++;
        assert (outs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b (busy,done,gt,lt,eq)", tag, outs, exp);
    endtask

    task automatic go(input logic [7:0] va, input logic [7:0] vb);
        a = va; b = vb; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
        #12;
        chk("reset_state", 5'b00000);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", 5'b00000);

        // Reset mid-COMPARE
        go(8'hA5, 8'hA5);
        chk("rst_mid_busy_e0", 5'b10000);
        tick();
        chk("rst_mid_busy_e1", 5'b10000);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async", 5'b00000);
        #2 rst_n = 1'b1;
        tick();
        chk("rst_mid_no_done_1", 5'b00000);
        tick();
        chk("rst_mid_no_done_2", 5'b00000);

        // Early termination on slice 0
        go(8'hC0, 8'h40);
        chk("gt_e0_busy", 5'b10000);
        tick();
        chk("gt_e1_done", 5'b01100);
        tick();
        chk("gt_hold", 5'b00100);

        // Decision on last slice, less-than
        go(8'h5A, 8'h5B);
        chk("lt_e0_busy_clear", 5'b10000);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("lt_e%0d_busy", i), 5'b10000);
        end
        tick();
        chk("lt_e4_done", 5'b01010);
        tick();
        chk("lt_hold", 5'b00010);

        // Equal operands then a new compare clears flags at acceptance
        go(8'h3C, 8'h3C);
        for (int i = 1; i < 4; i++) tick();
        chk("eq_e3_busy", 5'b10000);
        tick();
        chk("eq_e4_done", 5'b01001);
        tick();
        chk("eq_hold", 5'b00001);
        go(8'h00, 8'h01);
        chk("restart_clears", 5'b10000);
        for (int i = 1; i < 5; i++) tick();
        chk("lt01_e4_done", 5'b01010);

        // Abort in second COMPARE cycle, start held high throughout
        tick();
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick();
        chk("abort_e0_busy", 5'b10000);
        tick();
        chk("abort_e1_busy", 5'b10000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 5'b00000);
        tick();
        chk("held_start_reaccept", 5'b10000);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("held_e%0d_busy", i), 5'b10000);
        end
        tick();
        chk("held_done", 5'b01001);
        tick();
        chk("held_done_to_idle", 5'b00001);
        tick();
        chk("held_idle_accept", 5'b10000);
        start = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("held_abort_idle", 5'b00000);

        // Abort coinciding with final-slice equal decision
        go(8'hAA, 8'hAA);
        tick(); tick();
        chk("race_e2_busy", 5'b10000);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("race_abort_wins", 5'b00000);
        tick();
        chk("race_no_done", 5'b00000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

endmodule
